// File: rtl/seq_right_shifter_pkg.sv
// Shared constants for the sequential right shifter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_right_shifter_pkg;

    // Datapath width; the five-stage sequence below is sized for 32 bits only.
    localparam int WIDTH = 32;
    // Shift-amount width, log2(WIDTH).
    localparam int SHW = 5;

    // Highest stage index: the first SHIFT cycle handles a 2^4 = 16-bit move.
    localparam logic [2:0] LEVEL_TOP = 3'd4;

    // FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : seq_right_shifter_pkg

// File: rtl/seq_right_shifter_mux_level.sv
// One conditional right-shift stage: moves i_dat right by DIST when i_en is set.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module right_mux_level #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_en,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_dat
);

    logic [WIDTH-1:0] w_shifted;

    // Vacated MSBs take the fill bit (0 for logical, sign for arithmetic).
    assign w_shifted = {{DIST{i_fill}}, i_dat[WIDTH-1:DIST]};

    // Bypass when this stage's shamt bit is clear.
    assign o_dat = i_en ? w_shifted : i_dat;

endmodule : right_mux_level

// File: rtl/seq_right_shifter.sv
// Sequential barrel shifter: one power-of-two stage per cycle, 16/8/4/2/1.
// Latency: start accepted at edge N gives done during the cycle after edge N+5.
// Backpressure: start is only taken while ready; requests in SHIFT/DONE are dropped.
module seq_right_shifter
    import seq_right_shifter_pkg::*;
#(
    parameter int WIDTH = seq_right_shifter_pkg::WIDTH,
    parameter int SHW   = seq_right_shifter_pkg::SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_level;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_shamt;
    // Fill bit is resolved at capture time: arith AND the operand's sign.
    logic             r_fill;
    logic             w_accept;

    // One stage output per level; stage k moves by 2^k.
    logic [WIDTH-1:0] w_stage [SHW];
    logic [WIDTH-1:0] w_work_nxt;

    assign w_accept = (r_state == ST_IDLE) && start;

    // Build all five stages once; only the one picked by r_level is used each cycle.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        right_mux_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .i_dat  (r_work),
            .i_en   (r_shamt[k]),
            .i_fill (r_fill),
            .o_dat  (w_stage[k])
        );
    end

    // Select the stage matching the current level; out-of-range levels hold.
    always_comb begin
        w_work_nxt = r_work;
        case (r_level)
            3'd0:    w_work_nxt = w_stage[0];
            3'd1:    w_work_nxt = w_stage[1];
            3'd2:    w_work_nxt = w_stage[2];
            3'd3:    w_work_nxt = w_stage[3];
            3'd4:    w_work_nxt = w_stage[4];
            default: w_work_nxt = r_work;
        endcase
    end

    // Next-state logic: SHIFT exits after the level-0 cycle, DONE lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_level == 3'd0) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Level down-counter: loads the top stage on accept, stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 3'd0;
        end else if (w_accept) begin
            r_level <= LEVEL_TOP;
        end else if (r_state == ST_SHIFT && r_level != 3'd0) begin
            r_level <= r_level - 3'd1;
        end
    end

    // Operand capture on accept; later input changes cannot reach the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shamt <= '0;
            r_fill  <= 1'b0;
        end else if (w_accept) begin
            r_shamt <= shamt;
            r_fill  <= arith & data_in[WIDTH-1];
        end
    end

    // Working register: load on accept, apply one stage per SHIFT cycle, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
        end else if (w_accept) begin
            r_work <= data_in;
        end else if (r_state == ST_SHIFT) begin
            r_work <= w_work_nxt;
        end
    end

    assign ready  = (r_state == ST_IDLE);
    assign busy   = (r_state == ST_SHIFT);
    assign done   = (r_state == ST_DONE);
    assign result = r_work;

endmodule : seq_right_shifter

// File: doc/seq_right_shifter.md
SEQ_RIGHT_SHIFTER -- requirements
Module: seq_right_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits; only the value 32 is supported.
REQ-002 The block SHALL have parameter SHW, default 5, giving the shift-amount width (log2 WIDTH).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: request a shift; sampled only while ready=1.
REQ-006 Port data_in, input, 32 bits: operand; captured on the accepted start.
REQ-007 Port shamt, input, 5 bits: right-shift distance, 0-31; captured on the accepted start.
REQ-008 Port arith, input, 1 bit: 1 = arithmetic shift (sign fill), 0 = logical shift (zero fill); captured on the accepted start.
REQ-009 Port ready, output, 1 bit: high only in state IDLE.
REQ-010 Port busy, output, 1 bit: high only in state SHIFT.
REQ-011 Port done, output, 1 bit: single-cycle pulse, high only in state DONE.
REQ-012 Port result, output, 32 bits: shifted value; valid while done=1 and held until the next accepted start.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1, the block SHALL, at the clock edge, load the working register from data_in, latch shamt and arith, set level=4 and enter SHIFT.
REQ-015 In each SHIFT cycle, the working register SHALL shift right by 2^level when shamt[level]=1 and hold otherwise, then level SHALL decrement.
REQ-016 Vacated MSBs SHALL be filled with 0 when arith=0.
REQ-017 Vacated MSBs SHALL be filled with captured data_in[31] when arith=1.
REQ-018 The shift stages SHALL run in the order 16, 8, 4, 2, 1.
REQ-019 After the level-0 cycle, the FSM SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-021 Latency SHALL be fixed regardless of shamt: with start accepted at edge N, done SHALL be high during the cycle following edge N+5.
REQ-022 The state SHALL be IDLE again after edge N+6.
REQ-023 start asserted in SHIFT or DONE SHALL be ignored, with no queuing and no effect on the in-flight operation.
REQ-024 Changes to data_in, shamt or arith after capture SHALL NOT affect the result.
REQ-025 shamt=0 SHALL return data_in unchanged with full latency.
REQ-026 shamt=31 with arith=1 SHALL return all copies of the sign bit.
REQ-027 level SHALL be a 3-bit down-counter; it SHALL NOT wrap below 0, because SHIFT exits at 0.
REQ-028 result SHALL be driven directly from the working register.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, level=0, the working register and result to 0x00000000, ready=1, busy=0 and done=0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 The first start after reset release SHALL operate normally.

Structure
REQ-032 A shared package SHALL hold WIDTH, SHW and the FSM state encoding (IDLE, SHIFT, DONE).
REQ-033 A single combinational sub-module right_mux_level SHALL implement one conditional right shift by a parameterised distance with a fill bit.
REQ-034 seq_right_shifter SHALL reuse right_mux_level, selected by level.

Verification
REQ-035 Logical shift: data_in=0x80000000, shamt=31, arith=0 -> result=0x00000001, done high during the cycle after edge N+5.
REQ-036 Arithmetic shift: data_in=0x80000000, shamt=31, arith=1 -> result=0xFFFFFFFF.
REQ-037 Sign fill: data_in=0xF0F0F0F0, shamt=4, arith=1 -> 0xFF0F0F0F; same with arith=0 -> 0x0F0F0F0F.
REQ-038 Zero shift: data_in=0xDEADBEEF, shamt=0 -> 0xDEADBEEF, done still after edge N+5.
REQ-039 Start while busy: start with data_in=0x12345678, shamt=8, then start with data_in=0xFFFFFFFF two cycles later -> single done, result=0x00123456, second request dropped.
REQ-040 Reset mid-operation: rst_n=0 during SHIFT -> ready=1, busy=0, result=0 with no done pulse; next op 0x00000100 >> 8 -> 0x00000001.
